ifpad_seq_ctrl: RTL
===================

# ifpad_seq_ctrl

- Sequencing controller for one input-feature pad (12-entry 2-port RF plus handshake wrapper) inside a PE.
- Runs the pad as a circular sliding-window buffer:
  - fills the first window from the IF buffer;
  - replays each window a configured number of times toward the AU;
  - slides by a configured stride, overwriting the oldest entries;
  - pulses done after the last window.
- Drives the pad RF addresses and enables and owns both pixel handshakes. The pad datapath itself stays address-agnostic.

## Interface

**Clocking and reset (already decided):** one clock `i_clk`; reset `i_rst` is asynchronous and active-high.

Parameters (name, default, meaning):
- `PadSize`, 12: pad RF depth.
- `AddrWd`, `$clog2(PadSize)`: RF address width.
- `ConfDWd`, 4: width of the window-length and repeat fields.
- `PConfDWd`, 3: width of the stride field.
- `WinWd`, 8: width of the window-count field.

Ports (name, direction, width, meaning):
- `i_clk`, in, 1: clock.
- `i_rst`, in, 1: async active-high reset.
- `i_flush`, in, 1: synchronous abort to IDLE; highest priority after reset.
- `i_stall`, in, 1: freezes state and counters; forces `o_ipix_ready` and `o_opix_valid` low.
- `i_cfg_valid`, in, 1: config handshake valid.
- `o_cfg_ready`, out, 1: high only in IDLE.
- `i_cfg_r`, in, ConfDWd: window length R; legal range 1..PadSize.
- `i_cfg_stride`, in, PConfDWd: stride S; legal range 1..R.
- `i_cfg_rpt`, in, ConfDWd: reads per window; 0 is treated as 1.
- `i_cfg_nwin`, in, WinWd: number of windows; 0 is treated as 1.
- `o_cfg_err`, out, 1: one-cycle pulse when an illegal config is presented.
- `i_ipix_valid`, in, 1: pixel available from the IF buffer.
- `o_ipix_ready`, out, 1: controller accepts a pixel.
- `o_opix_valid`, out, 1: pad output pixel valid toward the AU.
- `i_opix_ready`, in, 1: AU accepts.
- `o_pad_we`, out, 1: RF write enable; equals `i_ipix_valid & o_ipix_ready`.
- `o_pad_waddr`, out, AddrWd: RF write address.
- `o_pad_re`, out, 1: RF read enable; equals `o_opix_valid & i_opix_ready`.
- `o_pad_raddr`, out, AddrWd: RF read address. The RF read is combinational.
- `o_rd_last`, out, 1: current read is the last of the last repeat of a window.
- `o_busy`, out, 1: state is not IDLE.
- `o_done`, out, 1: one-cycle pulse on completion.

## Operation

**States:** IDLE, FILL, READ, SLIDE, DONE.

**IDLE**
- `o_cfg_ready` = 1.
- On a config handshake with a legal config:
  - latch R, S, rpt, nwin;
  - clear `wptr`, `base`, `idx`, `rcnt`, `wcnt`;
  - go to FILL.
- Illegal config (R=0, R>PadSize, S=0, or S>R):
  - `o_cfg_err` pulses in the handshake cycle;
  - state stays IDLE.

**FILL**
- `o_ipix_ready` = 1.
- Each write goes to `wptr`; `wptr` increments modulo PadSize (wraps 11→0).
- After the R-th write, go to READ.

**READ**
- `o_opix_valid` = 1.
- `o_pad_raddr` = (`base` + `idx`) mod PadSize.
- Each read advances `idx`. When `idx` reaches R-1 it resets to 0 and `rcnt` increments.
- After the read with `idx`=R-1 and `rcnt`=rpt-1 (`o_rd_last`=1):
  - if `wcnt` = nwin-1, go to DONE;
  - otherwise go to SLIDE.

**SLIDE**
- Accept S pixels at `wptr`, which continues circularly.
- On the S-th write:
  - `base` ← (`base`+S) mod PadSize;
  - `wcnt`++;
  - go to READ.

**DONE**
- `o_done` = 1 for one cycle, then IDLE.

**Arithmetic**
- All address sums use a subtract-on-overflow wrap: sum ≥ PadSize ⇒ subtract PadSize.
- Widths are AddrWd+1 internally.

**Stall and flush**
- `i_stall` holds every register and masks both handshakes. No write or read occurs during stall.
- `i_flush` returns to IDLE on the next edge, discards the latched config, and outputs no `o_done`.
- `i_flush` together with `i_stall` ⇒ flush wins.

## Timing

- **Reset values:** state IDLE. `o_cfg_ready`=1. All other outputs 0, including `o_pad_waddr`/`o_pad_raddr`=0.
- **Config to FILL:** config accepted at cycle T ⇒ `o_ipix_ready` is high at T+1.
- **Combinational handshake outputs:** `o_pad_we`/`o_pad_re` are same-cycle functions of the handshakes. Pointer and counter updates land at the next edge.
- **Fill-to-read turnaround:** a FILL→READ transition after the last write at cycle t ⇒ `o_opix_valid` is high at t+1, raddr = `base`.
- **Best-case window cost:** R·rpt cycles of READ plus S cycles of SLIDE. There are no bubbles other than the state-transition edges listed.
- **Handshake stability:** `o_opix_valid` held high with `i_opix_ready` low ⇒ `o_pad_raddr` stays stable.
- **Async reset mid-operation:** every register returns to its reset value immediately; no `o_done`.

## Configuration

- **Macro `IFPAD_SEQ_PREFETCH_EN` defined:**
  - while in READ with R+S ≤ PadSize and `wcnt` < nwin-1, `o_ipix_ready` is also asserted;
  - up to S pixels are written into the free slots at `wptr`, counted in `pcnt`;
  - SLIDE then accepts only S−`pcnt` pixels and is skipped entirely when `pcnt`=S, giving a direct READ→READ window change;
  - if R+S > PadSize, behaviour equals the undefined case.
- **Macro undefined:** no write occurs outside FILL/SLIDE.

## Test plan

- **Basic slide:** R=3, S=1, rpt=2, nwin=3, pixels 1..5 ⇒ read addresses 0,1,2,0,1,2,1,2,3,1,2,3,2,3,4,2,3,4. `o_rd_last` on the 6th/12th/18th read; `o_done` one cycle after the 18th read.
- **Pointer wrap:** R=12, S=5, nwin=2 ⇒ SLIDE writes addrs 0..4 (wptr wrapped from 12); second window reads 5..11,0..4.
- **Illegal configs:** S=4 with R=3 ⇒ `o_cfg_err` pulse, state IDLE, `o_busy`=0. Same for R=13.
- **Backpressure and stall:** AU ready toggles 1-0-1 and `i_stall` is held 3 cycles mid-READ ⇒ raddr is stable during hold, no skipped or duplicated address, no RF enables during stall.
- **Abort:** `i_flush` in SLIDE after 1 of 2 writes ⇒ IDLE next cycle, no `o_done`, `o_cfg_ready`=1. `i_rst` mid-READ ⇒ all outputs at reset values asynchronously.
- **Prefetch:** with `IFPAD_SEQ_PREFETCH_EN`, R=4, S=2, rpt=1, nwin=2, ipix always valid ⇒ two writes to addrs 4,5 during READ; second window reads 2,3,4,5 starting the cycle after the first `o_rd_last`, and SLIDE never entered.

Source files
------------

// File: rtl/ifpad_seq_ctrl.sv
// Sequencer for one IF pad: fill, replay, slide a circular window.
// Optional `IFPAD_SEQ_PREFETCH_EN: prefetch next slide pixels in READ.
module ifpad_seq_ctrl #(
  parameter int PadSize  = 12,
  parameter int AddrWd   = $clog2(PadSize),
  parameter int ConfDWd  = 4,
  parameter int PConfDWd = 3,
  parameter int WinWd    = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_flush,
  input  logic                i_stall,
  input  logic                i_cfg_valid,
  output logic                o_cfg_ready,
  input  logic [ConfDWd-1:0]  i_cfg_r,
  input  logic [PConfDWd-1:0] i_cfg_stride,
  input  logic [ConfDWd-1:0]  i_cfg_rpt,
  input  logic [WinWd-1:0]    i_cfg_nwin,
  output logic                o_cfg_err,
  input  logic                i_ipix_valid,
  output logic                o_ipix_ready,
  output logic                o_opix_valid,
  input  logic                i_opix_ready,
  output logic                o_pad_we,
  output logic [AddrWd-1:0]   o_pad_waddr,
  output logic                o_pad_re,
  output logic [AddrWd-1:0]   o_pad_raddr,
  output logic                o_rd_last,
  output logic                o_busy,
  output logic                o_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_READ, S_SLIDE, S_DONE
  } state_e;

  localparam logic [AddrWd:0]  PadA = (AddrWd+1)'(PadSize);
  localparam logic [ConfDWd:0] PadC = (ConfDWd+1)'(PadSize);

  function automatic logic [AddrWd-1:0] wrap_add(
    input logic [AddrWd-1:0] a,
    input logic [AddrWd:0]   b
  );
    logic [AddrWd:0] sum;
    sum = {1'b0, a} + b;
    if (sum >= PadA) sum = sum - PadA;
    return sum[AddrWd-1:0];
  endfunction

  state_e state_q, state_d;
  logic [ConfDWd-1:0]  r_q, r_d, rpt_q, rpt_d;
  logic [ConfDWd-1:0]  rcnt_q, rcnt_d, cnt_q, cnt_d;
  logic [PConfDWd-1:0] s_q, s_d, pcnt_q, pcnt_d;
  logic [WinWd-1:0]    nwin_q, nwin_d, wcnt_q, wcnt_d;
  logic [AddrWd-1:0]   wptr_q, wptr_d, base_q, base_d;
  logic [AddrWd-1:0]   idx_q, idx_d;

  logic cfg_bad, cfg_hs, pref_ok, we, re;
  logic idx_end, rpt_end, win_end;
  logic [PConfDWd-1:0] pcnt_inc;
  logic [ConfDWd-1:0]  s_c;
  logic [AddrWd:0]     s_a;
  logic [AddrWd-1:0]   wptr_inc;

  assign s_c      = ConfDWd'(s_q);
  assign s_a      = (AddrWd+1)'(s_q);
  assign wptr_inc = wrap_add(wptr_q, (AddrWd+1)'(1));

  assign cfg_bad = (i_cfg_r == '0)
                 | ({1'b0, i_cfg_r} > PadC)
                 | (i_cfg_stride == '0)
                 | (ConfDWd'(i_cfg_stride) > i_cfg_r);

  assign idx_end = idx_q == AddrWd'(r_q - ConfDWd'(1));
  assign rpt_end = rcnt_q == rpt_q - ConfDWd'(1);
  assign win_end = wcnt_q == nwin_q - WinWd'(1);

`ifdef IFPAD_SEQ_PREFETCH_EN
  // Free slots exist only when the window plus one stride fits the pad.
  assign pref_ok = (state_q == S_READ)
                 & (({1'b0, r_q} + {1'b0, s_c}) <= PadC)
                 & (wcnt_q < nwin_q - WinWd'(1))
                 & (pcnt_q < s_q);
`else
  assign pref_ok = 1'b0;
`endif

  assign o_cfg_ready  = state_q == S_IDLE;
  assign cfg_hs       = o_cfg_ready & i_cfg_valid & ~i_stall & ~i_flush;
  assign o_cfg_err    = cfg_hs & cfg_bad;
  assign o_ipix_ready = ~i_stall & ((state_q == S_FILL)
                      | (state_q == S_SLIDE) | pref_ok);
  assign o_opix_valid = ~i_stall & (state_q == S_READ);
  assign we           = i_ipix_valid & o_ipix_ready;
  assign re           = o_opix_valid & i_opix_ready;
  assign o_pad_we     = we;
  assign o_pad_re     = re;
  assign o_pad_waddr  = wptr_q;
  assign o_pad_raddr  = wrap_add(base_q, {1'b0, idx_q});
  assign o_rd_last    = o_opix_valid & idx_end & rpt_end;
  assign o_busy       = state_q != S_IDLE;
  assign o_done       = state_q == S_DONE;
  assign pcnt_inc     = pcnt_q + PConfDWd'(we);

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    s_d     = s_q;
    rpt_d   = rpt_q;
    nwin_d  = nwin_q;
    rcnt_d  = rcnt_q;
    cnt_d   = cnt_q;
    pcnt_d  = pcnt_q;
    wcnt_d  = wcnt_q;
    wptr_d  = wptr_q;
    base_d  = base_q;
    idx_d   = idx_q;
    if (i_flush) begin
      state_d = S_IDLE;
      r_d     = '0;
      s_d     = '0;
      rpt_d   = '0;
      nwin_d  = '0;
      pcnt_d  = '0;
    end else if (!i_stall) begin
      unique case (state_q)
        S_IDLE: if (cfg_hs && !cfg_bad) begin
          r_d     = i_cfg_r;
          s_d     = i_cfg_stride;
          rpt_d   = (i_cfg_rpt == '0) ? ConfDWd'(1) : i_cfg_rpt;
          nwin_d  = (i_cfg_nwin == '0) ? WinWd'(1) : i_cfg_nwin;
          wptr_d  = '0;
          base_d  = '0;
          idx_d   = '0;
          rcnt_d  = '0;
          wcnt_d  = '0;
          cnt_d   = '0;
          pcnt_d  = '0;
          state_d = S_FILL;
        end
        S_FILL: if (we) begin
          wptr_d = wptr_inc;
          if (cnt_q == r_q - ConfDWd'(1)) begin
            cnt_d   = '0;
            state_d = S_READ;
          end else begin
            cnt_d = cnt_q + ConfDWd'(1);
          end
        end
        S_READ: begin
          if (we) begin
            wptr_d = wptr_inc;
            pcnt_d = pcnt_inc;
          end
          if (re) begin
            if (!idx_end) begin
              idx_d = idx_q + AddrWd'(1);
            end else begin
              idx_d = '0;
              if (!rpt_end) begin
                rcnt_d = rcnt_q + ConfDWd'(1);
              end else begin
                rcnt_d = '0;
                if (win_end) begin
                  state_d = S_DONE;
                end else if (pcnt_inc == s_q) begin
                  // Whole stride already prefetched: change window in place.
                  base_d = wrap_add(base_q, s_a);
                  wcnt_d = wcnt_q + WinWd'(1);
                  pcnt_d = '0;
                end else begin
                  cnt_d   = ConfDWd'(pcnt_inc);
                  pcnt_d  = '0;
                  state_d = S_SLIDE;
                end
              end
            end
          end
        end
        S_SLIDE: if (we) begin
          wptr_d = wptr_inc;
          if (cnt_q + ConfDWd'(1) == s_c) begin
            cnt_d   = '0;
            base_d  = wrap_add(base_q, s_a);
            wcnt_d  = wcnt_q + WinWd'(1);
            state_d = S_READ;
          end else begin
            cnt_d = cnt_q + ConfDWd'(1);
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      s_q     <= '0;
      rpt_q   <= '0;
      nwin_q  <= '0;
      rcnt_q  <= '0;
      cnt_q   <= '0;
      pcnt_q  <= '0;
      wcnt_q  <= '0;
      wptr_q  <= '0;
      base_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      s_q     <= s_d;
      rpt_q   <= rpt_d;
      nwin_q  <= nwin_d;
      rcnt_q  <= rcnt_d;
      cnt_q   <= cnt_d;
      pcnt_q  <= pcnt_d;
      wcnt_q  <= wcnt_d;
      wptr_q  <= wptr_d;
      base_q  <= base_d;
      idx_q   <= idx_d;
    end
  end

endmodule
